cpu_rng_source: RTL and testbench

Paced pseudo-random source for the CPU opponent in the tug-of-war game. It runs a 10-bit maximal-length LFSR that advances once every PERIOD enabled clocks. It presents the current value on a 10-bit bus to the downstream A > B comparator, which checks it against the difficulty setting. A one-cycle strobe tells the CPU-press logic when a fresh value, and so a fresh comparator result, is available.

---
 rtl/tug_pkg.sv | 18 +
 rtl/cpu_rng_source_tick_divider.sv | 34 +++
 rtl/cpu_rng_source.sv | 49 ++++
 tb/tb_cpu_rng_source.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war game datapath: LFSR geometry,
// the random-value type seen by the comparator, and the LFSR step function.
package tug_pkg;

    localparam int LFSR_W = 10;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;

    typedef logic [LFSR_W-1:0] rand_t;

    localparam rand_t LFSR_LOCK = 10'h3FF;

    // One Fibonacci step with XNOR feedback; all-ones is the only lockup state.
    function automatic rand_t lfsr_next(input rand_t cur);
        return {cur[LFSR_W-2:0], ~(cur[TAP_HI] ^ cur[TAP_LO])};
    endfunction

endpackage

// File: rtl/cpu_rng_source_tick_divider.sv
// Enable-gated modulo-PERIOD counter; flags the enabled edge that closes a period.
module tick_divider #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    // Tick is combinational here; the top registers everything it presents.
    assign tick = enable && (count == LAST);

    // Count enabled edges, wrapping at PERIOD-1; clear restarts the period.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) count <= '0;
            else               count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_rng_source.sv
// Paced pseudo-random source for the CPU opponent: a 10-bit maximal-length
// LFSR that advances once per PERIOD enabled clocks, plus a one-cycle strobe
// marking the first cycle a fresh value is visible.
module cpu_rng_source
    import tug_pkg::*;
#(
    parameter int PERIOD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value,
    output logic              step
);

    rand_t lfsr_q;
    logic  tick;

    tick_divider #(
        .PERIOD (PERIOD)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (seed_load),
        .tick   (tick)
    );

    // LFSR and strobe: reset, then seed load, then lockup guard / tick advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= '0;
            step   <= 1'b0;
        end else if (seed_load) begin
            // An all-ones seed would lock the XNOR LFSR, so it maps to zero.
            lfsr_q <= (seed == LFSR_LOCK) ? rand_t'(0) : seed;
            step   <= 1'b0;
        end else begin
            step <= tick;
            if (lfsr_q == LFSR_LOCK) lfsr_q <= '0;
            else if (tick)           lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign value = lfsr_q;

endmodule

// File: tb/tb_cpu_rng_source.sv
// Self-checking bench for cpu_rng_source (PERIOD = 4). A behavioural model
// pushes the expected post-edge value/step for each driven cycle onto a queue;
// each test pops and compares after the edge, plus fixed-value checks.
module tb_cpu_rng_source;
    import tug_pkg::*;

    localparam int P = 4;

    typedef struct packed {
        rand_t value;
        logic  step;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  enable = 1'b0;
    logic  seed_load = 1'b0;
    rand_t seed = '0;
    rand_t value;
    logic  step;

    int    checks = 0;
    int    errors = 0;

    exp_t  exp_q[$];
    exp_t  e;
    rand_t obs_val;
    logic  obs_step;

    rand_t m_val = '0;
    int    m_cnt = 0;
    logic  m_step = 1'b0;

    cpu_rng_source #(.PERIOD(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed      (seed),
        .value     (value),
        .step      (step)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic rand_t model_adv(input rand_t v);
        return {v[8:0], ~(v[9] ^ v[6])};
    endfunction

    // Model one clock edge and queue the expected post-edge outputs.
    task automatic model_edge(input logic r, input logic en, input logic ld, input rand_t sd);
        logic t;
        if (r) begin
            m_val = '0; m_cnt = 0; m_step = 1'b0;
        end else if (ld) begin
            m_val = (sd == 10'h3FF) ? 10'h000 : sd; m_cnt = 0; m_step = 1'b0;
        end else begin
            t = en && (m_cnt == P - 1);
            if (m_val == 10'h3FF) m_val = '0;
            else if (t)           m_val = model_adv(m_val);
            if (en) m_cnt = t ? 0 : m_cnt + 1;
            m_step = t;
        end
        exp_q.push_back('{value: m_val, step: m_step});
    endtask

    // Drive one cycle's inputs, model it, then sample the DUT 1 ns after the edge.
    task automatic drive_cycle(input logic r, input logic en, input logic ld, input rand_t sd);
        reset = r; enable = en; seed_load = ld; seed = sd;
        model_edge(r, en, ld, sd);
        @(posedge clk);
        #1;
        obs_val = value;
        obs_step = step;
    endtask

    task automatic test_reset();
        // Reset with seed_load and enable also high: reset must win.
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 10'h155);
            e = exp_q.pop_front();
            checks++;
            if (obs_val !== e.value || obs_step !== e.step) begin
                errors++;
                $display("FAIL reset_sb: got %h/%b expected %h/%b", obs_val, obs_step, e.value, e.step);
            end
        end
        checks++;
        if (obs_val !== 10'h000 || obs_step !== 1'b0) begin
            errors++;
            $display("FAIL reset_const: got %h/%b expected 000/0", obs_val, obs_step);
        end
    endtask

    task automatic test_sequence();
        rand_t vals [8] = '{10'h001, 10'h003, 10'h007, 10'h00F,
                            10'h01F, 10'h03F, 10'h07F, 10'h0FE};
        rand_t ev;
        logic  es;
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        void'(exp_q.pop_front());
        for (int k = 1; k <= 32; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs_val !== e.value || obs_step !== e.step) begin
                errors++;
                $display("FAIL seq_sb k=%0d: got %h/%b expected %h/%b", k, obs_val, obs_step, e.value, e.step);
            end
            es = (k % 4 == 0);
            ev = (k < 4) ? 10'h000 : vals[k/4 - 1];
            checks++;
            if (obs_val !== ev || obs_step !== es) begin
                errors++;
                $display("FAIL seq_const k=%0d: got %h/%b expected %h/%b", k, obs_val, obs_step, ev, es);
            end
        end
    endtask

    task automatic test_enable_hold();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 2 + 10 + 2; i++) begin
            drive_cycle(1'b0, (i < 2 || i >= 12), 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs_val !== e.value || obs_step !== e.step) begin
                errors++;
                $display("FAIL hold_sb i=%0d: got %h/%b expected %h/%b", i, obs_val, obs_step, e.value, e.step);
            end
        end
        // Second enabled edge after re-enable closes the interrupted period.
        checks++;
        if (obs_step !== 1'b1 || obs_val !== 10'h001) begin
            errors++;
            $display("FAIL hold_resume: got %h/%b expected 001/1", obs_val, obs_step);
        end
    endtask

    task automatic test_seed_load();
        drive_cycle(1'b0, 1'b1, 1'b1, 10'h155);
        e = exp_q.pop_front();
        checks++;
        if (obs_val !== 10'h155 || obs_step !== 1'b0 || obs_val !== e.value) begin
            errors++;
            $display("FAIL seed_load: got %h/%b expected 155/0", obs_val, obs_step);
        end
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs_val !== e.value || obs_step !== e.step) begin
                errors++;
                $display("FAIL seed_sb i=%0d: got %h/%b expected %h/%b", i, obs_val, obs_step, e.value, e.step);
            end
        end
        // 0x155 has bit9=0 and bit6=1, so the fed-back bit is 0: 0x2AA.
        checks++;
        if (obs_val !== 10'h2AA || obs_step !== 1'b1) begin
            errors++;
            $display("FAIL seed_tick: got %h/%b expected 2aa/1", obs_val, obs_step);
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 10'h3FF);
        e = exp_q.pop_front();
        checks++;
        if (obs_val !== 10'h000 || obs_val !== e.value || obs_step !== e.step) begin
            errors++;
            $display("FAIL seed_lock: got %h/%b expected 000/0", obs_val, obs_step);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            void'(exp_q.pop_front());
        end
        // Fourth enabled edge would tick; the load takes it instead.
        drive_cycle(1'b0, 1'b1, 1'b1, 10'h0AA);
        e = exp_q.pop_front();
        checks++;
        if (obs_val !== 10'h0AA || obs_step !== 1'b0 || obs_val !== e.value) begin
            errors++;
            $display("FAIL collide: got %h/%b expected 0aa/0", obs_val, obs_step);
        end
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs_val !== e.value || obs_step !== e.step || obs_step !== (i == 4)) begin
                errors++;
                $display("FAIL collide_sb i=%0d: got %h/%b expected %h/%b", i, obs_val, obs_step, e.value, e.step);
            end
        end
        // Reset mid-period abandons it: four more edges needed for a tick.
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        void'(exp_q.pop_front());
        drive_cycle(1'b1, 1'b1, 1'b0, '0);
        void'(exp_q.pop_front());
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs_step !== (i == 4) || obs_val !== e.value) begin
                errors++;
                $display("FAIL mid_reset i=%0d: got %h/%b expected %h/%b", i, obs_val, obs_step, e.value, (i == 4));
            end
        end
    endtask

    task automatic test_free_run();
        bit seen [1024];
        int ticks = 0;
        bit repeat_hit = 0;
        bit lock_hit = 0;
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        void'(exp_q.pop_front());
        seen[0] = 1'b1;
        for (int c = 0; c < 1023 * P && ticks < 1023; c++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs_val !== e.value || obs_step !== e.step) begin
                errors++;
                $display("FAIL free_sb c=%0d: got %h/%b expected %h/%b", c, obs_val, obs_step, e.value, e.step);
            end
            if (obs_val === 10'h3FF) lock_hit = 1'b1;
            if (obs_step === 1'b1) begin
                ticks++;
                if (ticks < 1023) begin
                    if (seen[obs_val]) repeat_hit = 1'b1;
                    seen[obs_val] = 1'b1;
                end
            end
        end
        checks++;
        if (ticks != 1023) begin
            errors++;
            $display("FAIL free_ticks: got %0d expected 1023", ticks);
        end
        checks++;
        if (obs_val !== 10'h000) begin
            errors++;
            $display("FAIL free_wrap: got %h expected 000", obs_val);
        end
        checks++;
        if (repeat_hit || lock_hit) begin
            errors++;
            $display("FAIL free_unique: repeat=%0b lockup=%0b expected 0/0", repeat_hit, lock_hit);
        end
    endtask

    task automatic test_lockup();
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        void'(exp_q.pop_front());
        // Hold the state at all-ones across one edge, enable low.
        force dut.lfsr_q = 10'h3FF;
        reset = 1'b0; enable = 1'b0; seed_load = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (value !== 10'h3FF) begin
            errors++;
            $display("FAIL lock_force: got %h expected 3ff", value);
        end
        release dut.lfsr_q;
        m_val = 10'h3FF;
        drive_cycle(1'b0, 1'b0, 1'b0, '0);
        e = exp_q.pop_front();
        checks++;
        if (obs_val !== 10'h000 || obs_step !== 1'b0 || obs_val !== e.value) begin
            errors++;
            $display("FAIL lock_guard: got %h/%b expected 000/0", obs_val, obs_step);
        end
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs_val !== e.value || obs_step !== e.step) begin
                errors++;
                $display("FAIL lock_sb i=%0d: got %h/%b expected %h/%b", i, obs_val, obs_step, e.value, e.step);
            end
        end
        checks++;
        if (obs_val !== 10'h001 || obs_step !== 1'b1) begin
            errors++;
            $display("FAIL lock_resume: got %h/%b expected 001/1", obs_val, obs_step);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_enable_hold();
        test_seed_load();
        test_back_to_back();
        test_free_run();
        test_lockup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
